clint_timer_ctrl: RTL and testbench

- Machine-mode timer and software-interrupt controller for the cpu6 SoC, in the CLINT style.
- Holds the 64-bit mtime counter, the 64-bit mtimecmp comparator and the msip bit, all memory-mapped on the core's data bus.
- Drives the core's machine timer interrupt and machine software interrupt lines.
- Instantiated in soc_top beside the data RAM; the address decoder routes CLINT-window accesses here.

---
 rtl/clint_timer_ctrl_pkg.sv | 37 +++
 rtl/clint_prescaler.sv | 42 ++++
 rtl/clint_timer_ctrl.sv | 142 ++++++++++++++
 tb/tb_clint_timer_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/clint_timer_ctrl_pkg.sv
// Shared CLINT definitions: register offsets, reset constants, SoC base address
// and the offset decoder used by the register block.
package clint_timer_ctrl_pkg;

  localparam logic [31:0] CLINT_BASE_ADDR   = 32'h0200_0000;
  localparam logic [31:0] CLINT_MSIP        = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_LO = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIMECMP_HI = 32'h0000_4004;
  localparam logic [31:0] CLINT_MTIME_LO    = 32'h0000_BFF8;
  localparam logic [31:0] CLINT_MTIME_HI    = 32'h0000_BFFC;

  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_NONE       = 3'd0,
    REG_MSIP       = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_MTIME_LO   = 3'd4,
    REG_MTIME_HI   = 3'd5
  } clint_reg_e;

  // Maps a word-aligned byte offset to the register it selects.
  function automatic clint_reg_e clint_decode(input logic [31:0] off);
    clint_reg_e sel;
    case (off)
      CLINT_MSIP:        sel = REG_MSIP;
      CLINT_MTIMECMP_LO: sel = REG_MTIMECMP_LO;
      CLINT_MTIMECMP_HI: sel = REG_MTIMECMP_HI;
      CLINT_MTIME_LO:    sel = REG_MTIME_LO;
      CLINT_MTIME_HI:    sel = REG_MTIME_HI;
      default:           sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Tick generator: one tick every TICK_DIV un-halted cycles, first tick on the
// first cycle after reset. TICK_DIV=0 behaves as 1.
module clint_prescaler #(
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic halt,
  output logic tick
);

  localparam int unsigned    DIV_EFF = (TICK_DIV == 0) ? 1 : TICK_DIV;
  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(DIV_EFF - 1);

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] cnt_nxt_s;

  assign tick = ~halt & (cnt_r == '0);

  // Next count: hold while halted, reload on tick, otherwise count down.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (halt) begin
      cnt_nxt_s = cnt_r;
    end else if (cnt_r == '0) begin
      cnt_nxt_s = RELOAD;
    end else begin
      cnt_nxt_s = cnt_r - DIV_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/clint_timer_ctrl.sv
// CLINT-style machine timer and software interrupt block: mtime, mtimecmp and
// msip on a single-cycle request bus with a one-cycle registered response.
module clint_timer_ctrl
  import clint_timer_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = CLINT_MTIMECMP_RST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              rvalid,
  output logic [XLEN-1:0]   rdata,
  output logic              err,
  input  logic              halt,
  output logic              timer_irq,
  output logic              soft_irq
);

  logic [31:0] offset_s;
  clint_reg_e  sel_s;
  logic        wr_s;
  logic        tick_s;
  logic [31:0] wdata_s;
  logic [31:0] read_data_s;
  logic        unmapped_s;

  logic [63:0] mtime_r;
  logic [63:0] mtime_nxt_s;
  logic [63:0] mtimecmp_r;
  logic [63:0] mtimecmp_nxt_s;
  logic        msip_r;
  logic        msip_nxt_s;

  logic              rvalid_r;
  logic [XLEN-1:0]   rdata_r;
  logic              err_r;
  logic              timer_irq_r;
  logic              soft_irq_r;

  clint_prescaler #(
    .DIV_W    (16),
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (reset),
    .halt  (halt),
    .tick  (tick_s)
  );

  assign wdata_s = wdata[31:0];
  assign wr_s    = req & we;

  // Word-align the offset and decode the addressed register.
  always_comb begin
    offset_s              = 32'd0;
    offset_s[ADDR_W-1:0]  = addr;
    offset_s[1:0]         = 2'b00;
    sel_s                 = clint_decode(offset_s);
    unmapped_s            = (sel_s == REG_NONE);
  end

  // Read mux samples the current register state, before any update this cycle.
  always_comb begin
    case (sel_s)
      REG_MSIP:        read_data_s = {31'd0, msip_r};
      REG_MTIMECMP_LO: read_data_s = mtimecmp_r[31:0];
      REG_MTIMECMP_HI: read_data_s = mtimecmp_r[63:32];
      REG_MTIME_LO:    read_data_s = mtime_r[31:0];
      REG_MTIME_HI:    read_data_s = mtime_r[63:32];
      default:         read_data_s = 32'd0;
    endcase
  end

  // A write to one half of mtime beats a coincident tick; the other half
  // keeps its old value rather than taking a carry.
  always_comb begin
    mtime_nxt_s = mtime_r;
    case ({wr_s && (sel_s == REG_MTIME_HI), wr_s && (sel_s == REG_MTIME_LO)})
      2'b01:   mtime_nxt_s = {mtime_r[63:32], wdata_s};
      2'b10:   mtime_nxt_s = {wdata_s, mtime_r[31:0]};
      default: mtime_nxt_s = tick_s ? (mtime_r + 64'd1) : mtime_r;
    endcase
  end

  // Next-state for mtimecmp and msip.
  always_comb begin
    mtimecmp_nxt_s = mtimecmp_r;
    msip_nxt_s     = msip_r;
    case (wr_s ? sel_s : REG_NONE)
      REG_MTIMECMP_LO: mtimecmp_nxt_s = {mtimecmp_r[63:32], wdata_s};
      REG_MTIMECMP_HI: mtimecmp_nxt_s = {wdata_s, mtimecmp_r[31:0]};
      REG_MSIP:        msip_nxt_s     = wdata_s[0];
      default: begin
        mtimecmp_nxt_s = mtimecmp_r;
        msip_nxt_s     = msip_r;
      end
    endcase
  end

  // Architectural registers and interrupt lines, compared on post-update values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_r     <= 64'd0;
      mtimecmp_r  <= MTIMECMP_RST;
      msip_r      <= 1'b0;
      timer_irq_r <= 1'b0;
      soft_irq_r  <= 1'b0;
    end else begin
      mtime_r     <= mtime_nxt_s;
      mtimecmp_r  <= mtimecmp_nxt_s;
      msip_r      <= msip_nxt_s;
      timer_irq_r <= (mtime_nxt_s >= mtimecmp_nxt_s);
      soft_irq_r  <= msip_nxt_s;
    end
  end

  // Bus response, one cycle after each request; write responses carry rdata=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      rvalid_r <= req;
      rdata_r  <= (req && !we) ? XLEN'(read_data_s) : '0;
      err_r    <= req & unmapped_s;
    end
  end

  assign rvalid    = rvalid_r;
  assign rdata     = rdata_r;
  assign err       = err_r;
  assign timer_irq = timer_irq_r;
  assign soft_irq  = soft_irq_r;

endmodule

// File: tb/tb_clint_timer_ctrl.sv
// Bench for clint_timer_ctrl: two instances (TICK_DIV 1 and 4) share stimulus and
// are each compared every cycle with a behavioural model of the register map.
module tb_clint_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        halt;

  logic        rvalid_o [2];
  logic [31:0] rdata_o  [2];
  logic        err_o    [2];
  logic        tirq_o   [2];
  logic        sirq_o   [2];

  int checks = 0;
  int errors = 0;

  logic [63:0] m_mtime  [2];
  logic [63:0] m_cmp    [2];
  logic        m_msip   [2];
  longint      m_active [2];
  longint      m_div    [2] = '{64'sd1, 64'sd4};

  logic        e_rvalid [2];
  logic [31:0] e_rdata  [2];
  logic        e_err    [2];
  logic        e_tirq   [2];
  logic        e_sirq   [2];

  always #5 clk = ~clk;

  clint_timer_ctrl #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rvalid(rvalid_o[0]), .rdata(rdata_o[0]), .err(err_o[0]), .halt(halt),
    .timer_irq(tirq_o[0]), .soft_irq(sirq_o[0])
  );

  clint_timer_ctrl #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rvalid(rvalid_o[1]), .rdata(rdata_o[1]), .err(err_o[1]), .halt(halt),
    .timer_irq(tirq_o[1]), .soft_irq(sirq_o[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: advance the model with the current inputs, then compare.
  task automatic step();
    logic [15:0] off;
    logic [31:0] rv;
    logic        mapped;
    logic        tick;
    logic [63:0] nt;
    logic [63:0] nc;
    logic        nm;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_mtime[k] = 64'd0;
        m_cmp[k]   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip[k]  = 1'b0;
        m_active[k] = 0;
        e_rvalid[k] = 1'b0;
        e_rdata[k]  = 32'd0;
        e_err[k]    = 1'b0;
        e_tirq[k]   = 1'b0;
        e_sirq[k]   = 1'b0;
      end else begin
        off    = addr & 16'hFFFC;
        rv     = 32'd0;
        mapped = 1'b1;
        case (off)
          16'h0000: rv = {31'd0, m_msip[k]};
          16'h4000: rv = m_cmp[k][31:0];
          16'h4004: rv = m_cmp[k][63:32];
          16'hBFF8: rv = m_mtime[k][31:0];
          16'hBFFC: rv = m_mtime[k][63:32];
          default:  mapped = 1'b0;
        endcase
        e_rvalid[k] = req;
        e_rdata[k]  = (req && !we) ? rv : 32'd0;
        e_err[k]    = req && !mapped;
        tick = !halt && ((m_active[k] % m_div[k]) == 0);
        if (!halt) m_active[k] = m_active[k] + 1;
        nt = tick ? m_mtime[k] + 64'd1 : m_mtime[k];
        nc = m_cmp[k];
        nm = m_msip[k];
        if (req && we) begin
          case (off)
            16'h0000: nm = wdata[0];
            16'h4000: nc[31:0] = wdata;
            16'h4004: nc[63:32] = wdata;
            16'hBFF8: nt = {m_mtime[k][63:32], wdata};
            16'hBFFC: nt = {wdata, m_mtime[k][31:0]};
            default: ;
          endcase
        end
        m_mtime[k] = nt;
        m_cmp[k]   = nc;
        m_msip[k]  = nm;
        e_tirq[k]  = (nt >= nc);
        e_sirq[k]  = nm;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rvalid[%0d]", k), 64'(rvalid_o[k]), 64'(e_rvalid[k]));
      chk($sformatf("rdata[%0d]", k), 64'(rdata_o[k]), 64'(e_rdata[k]));
      chk($sformatf("err[%0d]", k), 64'(err_o[k]), 64'(e_err[k]));
      chk($sformatf("timer_irq[%0d]", k), 64'(tirq_o[k]), 64'(e_tirq[k]));
      chk($sformatf("soft_irq[%0d]", k), 64'(sirq_o[k]), 64'(e_sirq[k]));
    end
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 32'd0;
    step();
  endtask

  task automatic do_read(input logic [15:0] a);
    req = 1'b1; we = 1'b0; addr = a; wdata = 32'd0;
    step();
    req = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    step();
    req = 1'b0; we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 32'd0; halt = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    idle();

    // Reset values of mtimecmp
    do_read(16'h4000);
    chk("rst_cmp_lo", 64'(rdata_o[0]), 64'h0000_0000_FFFF_FFFF);
    chk("rst_cmp_err", 64'(err_o[0]), 64'd0);
    do_read(16'h4004);
    chk("rst_cmp_hi", 64'(rdata_o[0]), 64'h0000_0000_FFFF_FFFF);
    chk("rst_tirq", 64'(tirq_o[0]), 64'd0);
    idle();

    // Compare threshold 0x10 and free-running mtime
    do_write(16'h4000, 32'h0000_0010);
    do_write(16'h4004, 32'h0000_0000);
    for (int i = 0; i < 20; i++) do_read(16'hBFF8);

    // Low-half wrap carries into the high half
    do_write(16'hBFF8, 32'hFFFF_FFFF);
    idle();
    do_read(16'hBFF8);
    chk("wrap_lo", 64'(rdata_o[0]), 64'd0);
    do_read(16'hBFFC);
    chk("wrap_hi", 64'(rdata_o[0]), 64'd1);

    // Tick-coincident write wins
    do_write(16'hBFF8, 32'h3030_3035);
    do_read(16'hBFF8);
    chk("tick_write", 64'(rdata_o[0]), 64'h0000_0000_3030_3035);

    do_write(16'hBFFC, 32'h0000_0000);
    chk("tirq_high", 64'(tirq_o[0]), 64'd1);
    do_write(16'h4004, 32'h0000_0001);
    chk("tirq_fall", 64'(tirq_o[0]), 64'd0);

    do_write(16'h0000, 32'h0000_0001);
    chk("msip_set", 64'(sirq_o[0]), 64'd1);
    do_read(16'h0000);
    chk("msip_read", 64'(rdata_o[0]), 64'd1);
    do_write(16'h0000, 32'h0000_0000);
    chk("msip_clr", 64'(sirq_o[0]), 64'd0);

    // Halt for three cycles in the middle of a stream of mtime reads
    for (int i = 0; i < 5; i++) do_read(16'hBFF8);
    halt = 1'b1;
    for (int i = 0; i < 3; i++) do_read(16'hBFF8);
    halt = 1'b0;
    for (int i = 0; i < 10; i++) do_read(16'hBFF8);

    // Unmapped offset
    do_read(16'h1234);
    chk("unmapped_rdata", 64'(rdata_o[0]), 64'd0);
    chk("unmapped_err", 64'(err_o[0]), 64'd1);
    do_write(16'h1234, 32'hDEAD_BEEF);

    // Randomised traffic with random halt
    for (int i = 0; i < 600; i++) begin
      req  = ($urandom_range(0, 3) != 0);
      we   = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 5))
        0:       addr = 16'h0000;
        1:       addr = 16'h4000;
        2:       addr = 16'h4004;
        3:       addr = 16'hBFF8;
        4:       addr = 16'hBFFC;
        default: addr = 16'($urandom_range(0, 65535));
      endcase
      addr  = addr | 16'($urandom_range(0, 3));
      wdata = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
      halt  = ($urandom_range(0, 4) == 0);
      step();
    end
    halt = 1'b0;
    idle();

    // Reset arrives while a read is outstanding
    req = 1'b1; we = 1'b0; addr = 16'hBFF8; reset = 1'b0;
    step();
    chk("rst_mid_rvalid", 64'(rvalid_o[0]), 64'd0);
    req = 1'b0;
    step();
    reset = 1'b1;
    idle();
    chk("post_rst_rvalid", 64'(rvalid_o[0]), 64'd0);
    do_read(16'hBFF8);
    chk("post_rst_mtime", 64'(rdata_o[0]), 64'd1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
